// File: rtl/jk_pkg.sv
// Shared types and JK excitation codes for the JK bank driver.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Codes are {j, k}.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic [1:0] jk_code(input logic cur, input logic tgt, input logic tgl);
        if (cur == tgt) begin
            return JK_HOLD;
        end else if (tgl) begin
            return JK_TGL;
        end else begin
            return tgt ? JK_SET : JK_RST;
        end
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational per-word JK excitation: codes that move cur to tgt in one clock.
module jk_excite
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic             tgl,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            {j[i], k[i]} = jk_code(cur[i], tgt[i], tgl);
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives j/k into a JK flip-flop bank until q matches the requested target, with retries.
// Optional JK_TOGGLE_EN: latch req_toggle and use the toggle code for differing bits.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic             req_toggle,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t            state_q;
    logic [WIDTH-1:0]  tgt_q;
    logic              tgl_q;
    logic [RW-1:0]     retry_q;
    logic [SW-1:0]     settle_q;

    logic              tgl_in;
    logic [WIDTH-1:0]  ex_tgt;
    logic              ex_tgl;
    logic [WIDTH-1:0]  ex_j;
    logic [WIDTH-1:0]  ex_k;
    logic              accept;

`ifdef JK_TOGGLE_EN
    assign tgl_in = req_toggle;
`else
    logic unused_req_toggle;
    assign unused_req_toggle = req_toggle;
    assign tgl_in = 1'b0;
`endif

    assign req_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign accept    = req_valid && req_ready;

    // In IDLE the excitation is for the incoming request; afterwards for the latched one.
    assign ex_tgt = (state_q == IDLE) ? req_target : tgt_q;
    assign ex_tgl = (state_q == IDLE) ? tgl_in : tgl_q;

    jk_excite #(
        .WIDTH(WIDTH)
    ) u_excite (
        .cur(q_fb),
        .tgt(ex_tgt),
        .tgl(ex_tgl),
        .j  (ex_j),
        .k  (ex_k)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            tgl_q    <= 1'b0;
            retry_q  <= '0;
            settle_q <= '0;
            j        <= '0;
            k        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    j <= '0;
                    k <= '0;
                    if (accept) begin
                        tgt_q   <= req_target;
                        tgl_q   <= tgl_in;
                        j       <= ex_j;
                        k       <= ex_k;
                        retry_q <= '0;
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    j        <= '0;
                    k        <= '0;
                    settle_q <= SW'(SETTLE - 1);
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - 1'b1;
                    end else if (q_fb == tgt_q) begin
                        done    <= 1'b1;
                        state_q <= IDLE;
                    end else if (32'(retry_q) < MAX_RETRY) begin
                        retry_q <= retry_q + 1'b1;
                        j       <= ex_j;
                        k       <= ex_k;
                        state_q <= APPLY;
                    end else begin
                        err     <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: behavioural JK bank, cycle-level request model, directed vectors.
module tb_jk_bank_driver;

    localparam int W  = 4;
    localparam int S  = 1;
    localparam int MR = 2;
    localparam int P  = S + 1;
`ifdef JK_TOGGLE_EN
    localparam bit TGL_EN = 1'b1;
`else
    localparam bit TGL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_toggle = 1'b0;
    logic [W-1:0] req_target = '0;
    logic         req_ready;
    logic [W-1:0] q_fb;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         busy;
    logic         done;
    logic         err;

    logic [W-1:0] bank = '0;
    logic [W-1:0] stuck = '0;
    assign q_fb = bank;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    jk_bank_driver #(
        .WIDTH    (W),
        .SETTLE   (S),
        .MAX_RETRY(MR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_target(req_target),
        .req_toggle(req_toggle),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {j, k} that moves cur to tgt: only differing bits are excited.
    function automatic logic [2*W-1:0] excite(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                              input logic tgl);
        logic [W-1:0] diff;
        diff = cur ^ tgt;
        return {diff & (tgt | {W{tgl}}), diff & (~tgt | {W{tgl}})};
    endfunction

    // Behavioural JK bank with an optional stuck-at-0 mask.
    always @(posedge clk) begin
        logic [W-1:0] nx;
        for (int i = 0; i < W; i++) begin
            case ({j[i], k[i]})
                2'b00:   nx[i] = bank[i];
                2'b01:   nx[i] = 1'b0;
                2'b10:   nx[i] = 1'b1;
                default: nx[i] = ~bank[i];
            endcase
        end
        bank <= nx & ~stuck;
    end

    // Request model: cycle index since accept; every P cycles is an apply cycle.
    bit           m_act = 1'b0;
    int           m_cyc = 0;
    int           m_att = 0;
    logic [W-1:0] m_tgt = '0;
    logic         m_tgl = 1'b0;
    logic [W-1:0] m_j = '0;
    logic [W-1:0] m_k = '0;
    bit           m_done = 1'b0;
    bit           m_err = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e_j;
        logic [W-1:0] e_k;
        bit nd;
        bit ne;
        if (rst) begin
            m_act  = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            chk("mdl_rst_jk", {j, k}, '0);
            chk("mdl_rst_flags", {req_ready, busy, done, err}, 4'b0000);
        end else begin
            e_j = (m_act && (m_cyc % P == 0)) ? m_j : '0;
            e_k = (m_act && (m_cyc % P == 0)) ? m_k : '0;
            chk("mdl_j", j, e_j);
            chk("mdl_k", k, e_k);
            chk("mdl_flags", {req_ready, busy, done, err}, {!m_act, m_act, m_done, m_err});
            nd = 1'b0;
            ne = 1'b0;
            if (m_act) begin
                if (m_cyc % P == P - 1) begin
                    if (q_fb == m_tgt) begin
                        nd    = 1'b1;
                        m_act = 1'b0;
                    end else if (m_att < MR) begin
                        m_att++;
                        {m_j, m_k} = excite(q_fb, m_tgt, m_tgl);
                        m_cyc++;
                    end else begin
                        ne    = 1'b1;
                        m_act = 1'b0;
                    end
                end else begin
                    m_cyc++;
                end
            end else if (req_valid) begin
                m_act = 1'b1;
                m_cyc = 0;
                m_att = 0;
                m_tgt = req_target;
                m_tgl = TGL_EN & req_toggle;
                {m_j, m_k} = excite(q_fb, req_target, m_tgl);
            end
            m_done = nd;
            m_err  = ne;
        end
    end

    task automatic start_req(input logic [W-1:0] tgt, input logic tgl);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!req_ready) chk("ready_wait", {31'd0, req_ready}, 1);
        req_valid  = 1'b1;
        req_target = tgt;
        req_toggle = tgl;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [W-1:0] tgt, input logic tgl, input logic hold,
                           output int lat, output logic gd, output logic ge,
                           output logic [W-1:0] j0, output logic [W-1:0] k0, output int applies);
        start_req(tgt, tgl);
        j0 = j;
        k0 = k;
        applies = 0;
        gd = 1'b0;
        ge = 1'b0;
        lat = -1;
        if (hold) begin
            req_valid  = 1'b1;
            req_target = 4'b1111;
        end
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == 1) req_valid = 1'b0;
            if ((j | k) != '0) applies++;
            if (done) gd = 1'b1;
            if (err) ge = 1'b1;
            if (done || err) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("req_timeout", 0, 1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int applies;
        logic gd;
        logic ge;
        logic [W-1:0] j0;
        logic [W-1:0] k0;
        bit pulse;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_jk", {j, k}, 8'h00);
        chk("rst_flags", {req_ready, busy, done, err}, 4'b0000);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 1);

        // Set/reset path
        run_req(4'b1010, 1'b0, 1'b0, lat, gd, ge, j0, k0, applies);
        chk("t2_j", j0, 4'b1010);
        chk("t2_k", k0, 4'b0000);
        chk("t2_lat", lat, 2);
        chk("t2_done_err", {gd, ge}, 2'b10);
        chk("t2_bank", q_fb, 4'b1010);

        // Toggle path
        run_req(4'b0110, 1'b1, 1'b0, lat, gd, ge, j0, k0, applies);
        chk("t3_j", j0, TGL_EN ? 4'b1100 : 4'b0100);
        chk("t3_k", k0, TGL_EN ? 4'b1100 : 4'b1000);
        chk("t3_done_err", {gd, ge}, 2'b10);
        chk("t3_bank", q_fb, 4'b0110);

        // No-change request, with req_valid held while busy
        run_req(4'b0110, 1'b0, 1'b1, lat, gd, ge, j0, k0, applies);
        chk("t5_jk", {j0, k0}, 8'h00);
        chk("t5_lat", lat, 2);
        chk("t5_done_err", {gd, ge}, 2'b10);
        @(posedge clk);
        #1;
        chk("t5_not_queued", {31'd0, busy}, 0);
        chk("t5_bank", q_fb, 4'b0110);

        // Stuck bit0 at 0
        stuck = 4'b0001;
        run_req(4'b0001, 1'b0, 1'b0, lat, gd, ge, j0, k0, applies);
        chk("t4_j", j0, 4'b0001);
        chk("t4_k", k0, 4'b0110);
        chk("t4_applies", applies, 3);
        chk("t4_lat", lat, 6);
        chk("t4_done_err", {gd, ge}, 2'b01);
        chk("t4_busy", {31'd0, busy}, 0);
        stuck = 4'b0000;

        // Reset during WAIT
        start_req(4'b1111, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6w_flags", {req_ready, busy, done, err}, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6w_ready", {31'd0, req_ready}, 1);
        pulse = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done || err) pulse = 1'b1;
        end
        chk("t6w_no_pulse", {31'd0, pulse}, 0);

        // Reset during APPLY: j/k must clear without waiting for a clock
        start_req(4'b0000, 1'b0);
        chk("t6a_k_pre", k, 4'b1111);
        #1;
        rst = 1'b1;
        #1;
        chk("t6a_jk_async", {j, k}, 8'h00);
        chk("t6a_busy", {31'd0, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6a_ready", {31'd0, req_ready}, 1);
        chk("t6a_bank", q_fb, 4'b1111);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
